ws2812b_write_arbiter: RTL

//   Shares the single (color, nb_led, write) update port of the ws2812b strip driver

---
 rtl/ws2812b_write_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ws2812b_write_arbiter.sv
// Round-robin arbiter sharing the ws2812b (color, nb_led, write) update port between
// NUM_REQ requesters, with LED index range check and a programmable post-write gap.
module ws2812b_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NB_LEDS    = 15,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [24*NUM_REQ-1:0] req_color,
  input  logic [32*NUM_REQ-1:0] req_led,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [23:0]           led_color,
  output logic [31:0]           led_number,
  output logic                  led_write,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] RR_RESET = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0] GAP_LOAD = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [31:0] MAX_LED = 32'(NB_LEDS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [7:0]         gap_cnt_q, gap_cnt_d;
  logic [23:0]        led_color_q, led_color_d;
  logic [31:0]        led_number_q, led_number_d;
  logic               led_write_q, led_write_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] req_err_q, req_err_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   grant;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [23:0]        grant_color;
  logic [31:0]        grant_led;
  logic               grant_in_range;

  // Scan from the requester after the last winner, wrapping, so the last winner goes last.
  always_comb begin : arbitrate
    int   idx;
    logic found;
    // NOTE: every signal assigned in a combinational block gets a default first;
    // a path that leaves it unassigned would infer a latch.
    idx   = 0;
    found = 1'b0;
    grant = rr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[IDX_W'(idx)]) begin
        grant = IDX_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign grant_onehot   = NUM_REQ'(1) << grant;
  assign grant_color    = req_color[24*grant +: 24];
  assign grant_led      = req_led[32*grant +: 32];
  assign grant_in_range = (grant_led != 32'd0) && (grant_led <= MAX_LED);

  // Outputs are computed one state early so they are registered yet appear in S_ISSUE.
  always_comb begin : next_state
    state_d      = state_q;
    rr_d         = rr_q;
    gap_cnt_d    = gap_cnt_q;
    led_color_d  = led_color_q;
    led_number_d = led_number_q;
    led_write_d  = 1'b0;
    req_ready_d  = '0;
    req_err_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          rr_d        = grant;
          req_ready_d = grant_onehot;
          if (grant_in_range) begin
            led_write_d  = 1'b1;
            led_color_d  = grant_color;
            led_number_d = grant_led;
          end else begin
            req_err_d = grant_onehot;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (GAP_CYCLES == 0 || (|req_err_q)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = GAP_LOAD;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == 8'd0) state_d = S_IDLE;
        else                   gap_cnt_d = gap_cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rr_q         <= RR_RESET;
      gap_cnt_q    <= 8'd0;
      led_color_q  <= 24'd0;
      led_number_q <= 32'd0;
      led_write_q  <= 1'b0;
      req_ready_q  <= '0;
      req_err_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gap_cnt_q    <= gap_cnt_d;
      led_color_q  <= led_color_d;
      led_number_q <= led_number_d;
      led_write_q  <= led_write_d;
      req_ready_q  <= req_ready_d;
      req_err_q    <= req_err_d;
      busy_q       <= busy_d;
    end
  end

  assign led_color  = led_color_q;
  assign led_number = led_number_q;
  assign led_write  = led_write_q;
  assign req_ready  = req_ready_q;
  assign req_err    = req_err_q;
  assign busy       = busy_q;

endmodule
